// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder endpoint: state encoding and
// protocol constants used by every peripheral sitting behind it.
`timescale 1ns/1ps
package spi_responder_pkg;

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        SHIFT_IN  = 6'b000010,
        DISPATCH  = 6'b000100,
        WAIT_CORE = 6'b001000,
        START_OUT = 6'b010000,
        SHIFT_OUT = 6'b100000
    } resp_state_e;

    localparam logic SPI_START_BIT = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_responder.sv
// Peripheral-side SPI endpoint: receives a request packet on MOSI, hands it to
// a compute core with a valid/valid handshake and returns the result on MISO.
`timescale 1ns/1ps
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int PacketWidth = 32,
    parameter int ResultWidth = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_nss,
    input  logic                   i_mosi,
    output logic                   o_miso,
    output logic                   o_req_valid,
    output logic [PacketWidth-1:0] o_req_data,
    input  logic                   i_rsp_valid,
    input  logic [ResultWidth-1:0] i_rsp_data,
    output logic                   o_busy
);

    localparam int CntW    = $clog2(max_int(PacketWidth, ResultWidth));
    localparam int PktIdxW = (PacketWidth > 1) ? $clog2(PacketWidth) : 1;
    localparam int RspIdxW = (ResultWidth > 1) ? $clog2(ResultWidth) : 1;

    localparam logic [CntW-1:0] PktLast = CntW'(PacketWidth - 1);
    localparam logic [CntW-1:0] RspLast = CntW'(ResultWidth - 1);

    resp_state_e            state_q, state_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PacketWidth-1:0] shreg_q, shreg_d;
    logic [PacketWidth-1:0] req_data_q, req_data_d;
    logic [ResultWidth-1:0] rsp_q, rsp_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            req_data_q <= '0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            req_data_q <= req_data_d;
            rsp_q      <= rsp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        req_data_d = req_data_q;
        rsp_d      = rsp_q;

        // Deselect abandons any transaction in flight; captured data is kept.
        if (i_nss && (state_q != IDLE)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_nss && (i_mosi == SPI_START_BIT)) begin
                        state_d   = SHIFT_IN;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT_IN: begin
                    shreg_d[bit_cnt_q[PktIdxW-1:0]] = i_mosi;
                    if (bit_cnt_q == PktLast) begin
                        // Publish the packet including the bit arriving on this edge.
                        state_d    = DISPATCH;
                        bit_cnt_d  = '0;
                        req_data_d = shreg_d;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
                DISPATCH: begin
                    state_d = WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (i_rsp_valid) begin
                        rsp_d   = i_rsp_data;
                        state_d = START_OUT;
                    end
                end
                START_OUT: begin
                    state_d   = SHIFT_OUT;
                    bit_cnt_d = '0;
                end
                SHIFT_OUT: begin
                    if (bit_cnt_q == RspLast) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // MISO is wired-OR at the top level, so it must be low while deselected.
    always_comb begin
        o_miso = 1'b0;
        if (!i_nss) begin
            case (state_q)
                START_OUT: o_miso = SPI_START_BIT;
                SHIFT_OUT: o_miso = rsp_q[bit_cnt_q[RspIdxW-1:0]];
                default:   o_miso = 1'b0;
            endcase
        end
    end

    assign o_req_valid = (state_q == DISPATCH);
    assign o_req_data  = req_data_q;
    assign o_busy      = (state_q != IDLE);

endmodule
